snake_body_engine: RTL



---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_hit_scan.sv | 59 +++++
 rtl/snake_body_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction/state types, geometry defaults and reverse-direction helper
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam int DEF_COORD_W   = 10;
  localparam int DEF_GRID_STEP = 10;
  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_SCREEN_H  = 480;
  localparam int DEF_MAX_LEN   = 16;
  localparam int DEF_INIT_LEN  = 4;
  localparam int DEF_INIT_X    = 40;
  localparam int DEF_INIT_Y    = 240;

  // Opposite heading: flipping the top code bit swaps UP/DOWN and RIGHT/LEFT
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'({~d[1], d[0]});
  endfunction

endpackage

// File: rtl/snake_hit_scan.sv
// rtl/snake_hit_scan.sv - per-segment box comparators: registered pixel hit and combinational probe hit
module snake_hit_scan #(
  parameter int COORD_W   = 10,
  parameter int GRID_STEP = 10,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [MAX_LEN*COORD_W-1:0] seg_x_i,
  input  logic [MAX_LEN*COORD_W-1:0] seg_y_i,
  input  logic [COORD_W-1:0]         pix_x_i,
  input  logic [COORD_W-1:0]         pix_y_i,
  input  logic [LEN_W-1:0]           pix_cnt_i,
  input  logic [COORD_W-1:0]         probe_x_i,
  input  logic [COORD_W-1:0]         probe_y_i,
  input  logic [LEN_W-1:0]           probe_cnt_i,
  output logic                       pix_hit_o,
  output logic                       probe_hit_o
);

  localparam int EW = COORD_W + 1;

  logic pix_hit_d;
  logic pix_hit_q;

  // Point (px,py) lies inside the GRID_STEP square whose origin is (sx,sy)
  function automatic logic in_box(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                  input logic [COORD_W-1:0] sx, input logic [COORD_W-1:0] sy);
    logic [COORD_W:0] ex;
    logic [COORD_W:0] ey;
    ex = {1'b0, sx} + EW'(GRID_STEP);
    ey = {1'b0, sy} + EW'(GRID_STEP);
    return (px >= sx) && ({1'b0, px} < ex) && (py >= sy) && ({1'b0, py} < ey);
  endfunction

  // Compare both query points against every slot below its own active count
  always_comb begin
    pix_hit_d   = 1'b0;
    probe_hit_o = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < pix_cnt_i) &&
          in_box(pix_x_i, pix_y_i, seg_x_i[i*COORD_W +: COORD_W], seg_y_i[i*COORD_W +: COORD_W]))
        pix_hit_d = 1'b1;
      if ((LEN_W'(i) < probe_cnt_i) &&
          in_box(probe_x_i, probe_y_i, seg_x_i[i*COORD_W +: COORD_W], seg_y_i[i*COORD_W +: COORD_W]))
        probe_hit_o = 1'b1;
    end
  end

  // Renderer hit is registered to give a fixed one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_hit_q <= 1'b0;
    else        pix_hit_q <= pix_hit_d;
  end

  assign pix_hit_o = pix_hit_q;

endmodule

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake segment engine (define SNAKE_WRAP_EN for edge wrap-around instead of wall collision)
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int GRID_STEP = DEF_GRID_STEP,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int INIT_LEN  = DEF_INIT_LEN,
  parameter int INIT_X    = DEF_INIT_X,
  parameter int INIT_Y    = DEF_INIT_Y
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           dir_valid,
  input  logic [1:0]                     dir,
  input  logic [COORD_W-1:0]             food_x,
  input  logic [COORD_W-1:0]             food_y,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  output logic [COORD_W-1:0]             head_x,
  output logic [COORD_W-1:0]             head_y,
  output logic [COORD_W-1:0]             tail_x,
  output logic [COORD_W-1:0]             tail_y,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           ate,
  output logic                           game_over,
  output logic                           body_hit
);

  localparam int                 LEN_W      = $clog2(MAX_LEN + 1);
  localparam int                 SW         = COORD_W + 1;
  localparam logic signed [SW-1:0] STEP_S   = SW'(GRID_STEP);
  localparam logic signed [SW-1:0] X_MAX_S  = SW'(SCREEN_W - GRID_STEP);
  localparam logic signed [SW-1:0] Y_MAX_S  = SW'(SCREEN_H - GRID_STEP);
  localparam logic [LEN_W-1:0]   MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   INIT_LEN_L = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0]   ONE_L      = LEN_W'(1);

  state_t state_q, state_d;
  dir_t   pend_dir_q, pend_dir_d;
  dir_t   last_dir_q, last_dir_d;
  dir_t   ref_dir;

  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic [COORD_W-1:0] seg_x_d [MAX_LEN];
  logic [COORD_W-1:0] seg_y_d [MAX_LEN];
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ate_q, ate_d;
  logic               over_q, over_d;

  logic [MAX_LEN*COORD_W-1:0] seg_x_flat;
  logic [MAX_LEN*COORD_W-1:0] seg_y_flat;
  logic signed [SW-1:0]       nx_s, ny_s;
  logic [COORD_W-1:0]         next_x, next_y;
  logic                       wall_hit, self_hit, grow, step, collide;
  logic [LEN_W-1:0]           self_cnt, tail_idx;

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign seg_x_flat[g*COORD_W +: COORD_W] = seg_x_q[g];
    assign seg_y_flat[g*COORD_W +: COORD_W] = seg_y_q[g];
  end

  // Candidate head one grid step along the buffered direction; signed so edges can go negative
  always_comb begin
    nx_s = signed'({1'b0, seg_x_q[0]});
    ny_s = signed'({1'b0, seg_y_q[0]});
    case (pend_dir_q)
      UP:      ny_s = ny_s - STEP_S;
      DOWN:    ny_s = ny_s + STEP_S;
      LEFT:    nx_s = nx_s - STEP_S;
      default: nx_s = nx_s + STEP_S;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  localparam logic [COORD_W-1:0] X_MAX_U = COORD_W'(SCREEN_W - GRID_STEP);
  localparam logic [COORD_W-1:0] Y_MAX_U = COORD_W'(SCREEN_H - GRID_STEP);

  assign wall_hit = 1'b0;

  // Fold a candidate that left the playfield back onto the opposite edge
  always_comb begin
    next_x = nx_s[COORD_W-1:0];
    next_y = ny_s[COORD_W-1:0];
    if (nx_s[SW-1])          next_x = X_MAX_U;
    else if (nx_s > X_MAX_S) next_x = '0;
    if (ny_s[SW-1])          next_y = Y_MAX_U;
    else if (ny_s > Y_MAX_S) next_y = '0;
  end
`else
  assign wall_hit = nx_s[SW-1] || (nx_s > X_MAX_S) || ny_s[SW-1] || (ny_s > Y_MAX_S);
  assign next_x   = nx_s[COORD_W-1:0];
  assign next_y   = ny_s[COORD_W-1:0];
`endif

  assign step     = (state_q == RUN) && tick;
  assign grow     = (next_x == food_x) && (next_y == food_y) && (len_q < MAX_LEN_L);
  // The tail vacates its cell on a plain move, so it only counts when the snake grows
  assign self_cnt = grow ? len_q : len_q - ONE_L;
  assign collide  = step && (wall_hit || self_hit);
  // A request arriving with a tick is judged against the heading that tick uses
  assign ref_dir  = step ? pend_dir_q : last_dir_q;
  assign tail_idx = len_q - ONE_L;

  snake_hit_scan #(
    .COORD_W   (COORD_W),
    .GRID_STEP (GRID_STEP),
    .MAX_LEN   (MAX_LEN),
    .LEN_W     (LEN_W)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_x_i     (seg_x_flat),
    .seg_y_i     (seg_y_flat),
    .pix_x_i     (pix_x),
    .pix_y_i     (pix_y),
    .pix_cnt_i   (len_q),
    .probe_x_i   (next_x),
    .probe_y_i   (next_y),
    .probe_cnt_i (self_cnt),
    .pix_hit_o   (body_hit),
    .probe_hit_o (self_hit)
  );

  // Game state transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (collide) state_d = OVER;
               else if (pause) state_d = PAUSE;
      PAUSE:   if (!pause) state_d = RUN;
      OVER:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Direction buffer, segment shift/grow, and re-initialisation whenever the game sits in IDLE
  always_comb begin
    pend_dir_d = pend_dir_q;
    last_dir_d = last_dir_q;
    seg_x_d    = seg_x_q;
    seg_y_d    = seg_y_q;
    len_d      = len_q;
    ate_d      = 1'b0;
    over_d     = over_q;

    if (dir_valid && (state_q == RUN || state_q == PAUSE) && (dir_t'(dir) != reverse_dir(ref_dir)))
      pend_dir_d = dir_t'(dir);

    if (collide) begin
      over_d = 1'b1;
    end else if (step) begin
      seg_x_d[0] = next_x;
      seg_y_d[0] = next_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      last_dir_d = pend_dir_q;
      if (grow) begin
        len_d = len_q + ONE_L;
        ate_d = 1'b1;
      end
    end

    if (state_d == IDLE) begin
      pend_dir_d = RIGHT;
      last_dir_d = RIGHT;
      len_d      = INIT_LEN_L;
      ate_d      = 1'b0;
      over_d     = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = COORD_W'(INIT_X - i * GRID_STEP);
        seg_y_d[i] = COORD_W'(INIT_Y);
      end
    end
  end

  // State and body registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_dir_q <= RIGHT;
      last_dir_q <= RIGHT;
      len_q      <= INIT_LEN_L;
      ate_q      <= 1'b0;
      over_q     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= COORD_W'(INIT_X - i * GRID_STEP);
        seg_y_q[i] <= COORD_W'(INIT_Y);
      end
    end else begin
      state_q    <= state_d;
      pend_dir_q <= pend_dir_d;
      last_dir_q <= last_dir_d;
      len_q      <= len_d;
      ate_q      <= ate_d;
      over_q     <= over_d;
      seg_x_q    <= seg_x_d;
      seg_y_q    <= seg_y_d;
    end
  end

  // Tail is the last active slot
  always_comb begin
    tail_x = seg_x_q[0];
    tail_y = seg_y_q[0];
    for (int i = 0; i < MAX_LEN; i++) begin
      if (tail_idx == LEN_W'(i)) begin
        tail_x = seg_x_q[i];
        tail_y = seg_y_q[i];
      end
    end
  end

  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = len_q;
  assign ate       = ate_q;
  assign game_over = over_q;

endmodule
